// File: rtl/mv_seq_ctrl.sv
// mv_seq_ctrl -- matrix-vector compute sequencer.
//
// After Start (with a legal N) this block sweeps the A memory row-major and
// the X memory by column, one element per cycle, and drives the MAC controls
// aligned to the memory read data. The Y memory is written once per row, and
// Done pulses after the last row write.
//
// Optional feature macro: MVC_ABORT_EN (adds Abort_in, which cancels a job).
//
// Parameters:
//   RD_LAT  A/X memory read latency in cycles (1..4)
//   N_MAX   largest legal dimension
// Ports:
//   clk, RST_n                  clock, async active-low reset
//   Start_in, N_in              job request and dimension (sampled in IDLE)
//   Abort_in                    job cancel (MVC_ABORT_EN builds only)
//   A_Ena_out, A_Addra_out      A read port (address = row*N + col)
//   X_Ena_out, X_Addra_out      X read port (address = col)
//   Mac_en/clr/last_out         MAC operand valid, load-not-accumulate, row end
//   Y_Wena_out, Y_Addra_out     Y write port (address = row)
//   Busy_out, Done_out, Err_out job status
module mv_seq_ctrl #(
   parameter int RD_LAT = 1,
   parameter int N_MAX  = 128
) (
   input  logic        clk,
   input  logic        RST_n,
   input  logic        Start_in,
   input  logic [7:0]  N_in,
`ifdef MVC_ABORT_EN
   input  logic        Abort_in,
`endif
   output logic        A_Ena_out,
   output logic [13:0] A_Addra_out,
   output logic        X_Ena_out,
   output logic [6:0]  X_Addra_out,
   output logic        Mac_en_out,
   output logic        Mac_clr_out,
   output logic        Mac_last_out,
   output logic        Y_Wena_out,
   output logic [6:0]  Y_Addra_out,
   output logic        Busy_out,
   output logic        Done_out,
   output logic        Err_out
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [7:0] NMAX8 = 8'(N_MAX);

   state_t                   state_q, state_d;
   logic [7:0]               n_q, n_d;
   logic [6:0]               row_q, row_d;
   logic [6:0]               col_q, col_d;
   logic                     a_ena_q, a_ena_d;
   logic [13:0]              a_addr_q, a_addr_d;
   logic [6:0]               x_addr_q, x_addr_d;
   // Side-band pipeline: slot 0 is loaded from the issue cycle, slot
   // RD_LAT-1 lines up with the read data on the memory output bus.
   logic [RD_LAT-1:0]        vld_pipe_q, vld_pipe_d;
   logic [RD_LAT-1:0]        clr_pipe_q, clr_pipe_d;
   logic [RD_LAT-1:0]        last_pipe_q, last_pipe_d;
   logic [RD_LAT-1:0][6:0]   row_pipe_q, row_pipe_d;
   logic                     y_wena_q, y_wena_d;
   logic [6:0]               y_addr_q, y_addr_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;

   logic [7:0] n_m1;
   logic       issue, col_wrap, row_last, last_issue, start_ok, abort;

   assign n_m1       = n_q - 8'd1;
   // An issue happens in every cycle the read enable is up.
   assign issue      = a_ena_q;
   assign col_wrap   = ({1'b0, col_q} == n_m1);
   assign row_last   = ({1'b0, row_q} == n_m1);
   assign last_issue = issue & col_wrap & row_last;
   assign start_ok   = (N_in != 8'd0) && (N_in <= NMAX8);

`ifdef MVC_ABORT_EN
   assign abort = Abort_in && ((state_q == RUN) || (state_q == DRAIN));
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      row_d    = row_q;
      col_d    = col_q;
      a_ena_d  = 1'b0;
      a_addr_d = '0;
      x_addr_d = '0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      vld_pipe_d[0]  = issue;
      clr_pipe_d[0]  = issue & (col_q == 7'd0);
      last_pipe_d[0] = issue & col_wrap;
      row_pipe_d[0]  = row_q;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_pipe_d[i]  = vld_pipe_q[i-1];
         clr_pipe_d[i]  = clr_pipe_q[i-1];
         last_pipe_d[i] = last_pipe_q[i-1];
         row_pipe_d[i]  = row_pipe_q[i-1];
      end

      // A row's result is complete the cycle after its last MAC operand.
      y_wena_d = vld_pipe_q[RD_LAT-1] & last_pipe_q[RD_LAT-1];
      y_addr_d = y_wena_d ? row_pipe_q[RD_LAT-1] : 7'd0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (Start_in) begin
               if (start_ok) begin
                  state_d = RUN;
                  n_d     = N_in;
                  row_d   = '0;
                  col_d   = '0;
                  a_ena_d = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (last_issue) begin
               state_d = DRAIN;
               row_d   = '0;
               col_d   = '0;
            end else begin
               a_ena_d  = 1'b1;
               a_addr_d = a_addr_q + 14'd1;
               if (col_wrap) begin
                  col_d = '0;
                  row_d = row_q + 7'd1;
               end else begin
                  col_d = col_q + 7'd1;
               end
               x_addr_d = col_d;
            end
         end
         DRAIN: begin
            // Rows are written in order, so the row N-1 write is the final one.
            if (y_wena_q && ({1'b0, y_addr_q} == n_m1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      // Abort discards everything in flight and reports through Err.
      if (abort) begin
         state_d     = IDLE;
         row_d       = '0;
         col_d       = '0;
         a_ena_d     = 1'b0;
         a_addr_d    = '0;
         x_addr_d    = '0;
         vld_pipe_d  = '0;
         clr_pipe_d  = '0;
         last_pipe_d = '0;
         y_wena_d    = 1'b0;
         y_addr_d    = '0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         err_d       = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         state_q     <= IDLE;
         n_q         <= '0;
         row_q       <= '0;
         col_q       <= '0;
         a_ena_q     <= 1'b0;
         a_addr_q    <= '0;
         x_addr_q    <= '0;
         vld_pipe_q  <= '0;
         clr_pipe_q  <= '0;
         last_pipe_q <= '0;
         row_pipe_q  <= '0;
         y_wena_q    <= 1'b0;
         y_addr_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         row_q       <= row_d;
         col_q       <= col_d;
         a_ena_q     <= a_ena_d;
         a_addr_q    <= a_addr_d;
         x_addr_q    <= x_addr_d;
         vld_pipe_q  <= vld_pipe_d;
         clr_pipe_q  <= clr_pipe_d;
         last_pipe_q <= last_pipe_d;
         row_pipe_q  <= row_pipe_d;
         y_wena_q    <= y_wena_d;
         y_addr_q    <= y_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign A_Ena_out    = a_ena_q;
   assign A_Addra_out  = a_addr_q;
   assign X_Ena_out    = a_ena_q;
   assign X_Addra_out  = x_addr_q;
   assign Mac_en_out   = vld_pipe_q[RD_LAT-1];
   assign Mac_clr_out  = clr_pipe_q[RD_LAT-1];
   assign Mac_last_out = last_pipe_q[RD_LAT-1];
   assign Y_Wena_out   = y_wena_q;
   assign Y_Addra_out  = y_addr_q;
   assign Busy_out     = busy_q;
   assign Done_out     = done_q;
   assign Err_out      = err_q;

endmodule

// File: tb/tb_mv_seq_ctrl.sv
// Bench for mv_seq_ctrl: two instances (RD_LAT=1 and RD_LAT=2) share one
// stimulus stream; every cycle each is compared with an arithmetic model of
// the job timeline.
module tb_mv_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  n_in;
   logic        abort;

   logic [1:0]        a_ena, x_ena, mac_en, mac_clr, mac_last, y_wena, busy, done, err;
   logic [1:0][13:0]  a_addr;
   logic [1:0][6:0]   x_addr, y_addr;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mv_seq_ctrl #(.RD_LAT(1), .N_MAX(128)) u_dut1 (
      .clk(clk), .RST_n(rst_n), .Start_in(start), .N_in(n_in),
`ifdef MVC_ABORT_EN
      .Abort_in(abort),
`endif
      .A_Ena_out(a_ena[0]), .A_Addra_out(a_addr[0]),
      .X_Ena_out(x_ena[0]), .X_Addra_out(x_addr[0]),
      .Mac_en_out(mac_en[0]), .Mac_clr_out(mac_clr[0]), .Mac_last_out(mac_last[0]),
      .Y_Wena_out(y_wena[0]), .Y_Addra_out(y_addr[0]),
      .Busy_out(busy[0]), .Done_out(done[0]), .Err_out(err[0]));

   mv_seq_ctrl #(.RD_LAT(2), .N_MAX(128)) u_dut2 (
      .clk(clk), .RST_n(rst_n), .Start_in(start), .N_in(n_in),
`ifdef MVC_ABORT_EN
      .Abort_in(abort),
`endif
      .A_Ena_out(a_ena[1]), .A_Addra_out(a_addr[1]),
      .X_Ena_out(x_ena[1]), .X_Addra_out(x_addr[1]),
      .Mac_en_out(mac_en[1]), .Mac_clr_out(mac_clr[1]), .Mac_last_out(mac_last[1]),
      .Y_Wena_out(y_wena[1]), .Y_Addra_out(y_addr[1]),
      .Busy_out(busy[1]), .Done_out(done[1]), .Err_out(err[1]));

   // Output vector layout: 36 a_ena, 35:22 a_addr, 21 x_ena, 20:14 x_addr,
   // 13 mac_en, 12 clr, 11 last, 10 y_wena, 9:3 y_addr, 2 busy, 1 done, 0 err.
   function automatic logic [36:0] got_vec(input int d);
      return {a_ena[d], a_addr[d], x_ena[d], x_addr[d], mac_en[d], mac_clr[d],
              mac_last[d], y_wena[d], y_addr[d], busy[d], done[d], err[d]};
   endfunction

   // Addresses are don't-care while their enable is expected low.
   function automatic logic [36:0] msk(input logic [36:0] g, input logic [36:0] e);
      logic [36:0] r;
      r = g;
      if (!e[36]) r[35:22] = '0;
      if (!e[21]) r[20:14] = '0;
      if (!e[10]) r[9:3]   = '0;
      return r;
   endfunction

   // Expected outputs in cycle k after the accepting edge (k=1 is the first
   // issue cycle) for a legal job of dimension n and read latency lat.
   function automatic logic [36:0] exp_job(input int n, input int lat, input int k);
      logic [36:0] r;
      int nn, i, j;
      r  = '0;
      nn = n * n;
      if (k >= 1 && k <= nn) begin
         r[36]    = 1'b1;
         r[35:22] = 14'(k - 1);
         r[21]    = 1'b1;
         r[20:14] = 7'((k - 1) % n);
      end
      if (k >= 1 + lat && k <= nn + lat) begin
         i     = k - 1 - lat;
         r[13] = 1'b1;
         r[12] = (i % n == 0);
         r[11] = (i % n == n - 1);
      end
      j = k - 2 - lat;
      if (j >= 0 && j < nn && (j % n) == n - 1) begin
         r[10]  = 1'b1;
         r[9:3] = 7'(j / n);
      end
      r[2] = (k >= 1 && k <= nn + lat + 2);
      r[1] = (k == nn + lat + 2);
      return r;
   endfunction

   task automatic chk(input string nm, input int k, input logic [36:0] e0, input logic [36:0] e1);
      logic [36:0] g, e;
      for (int d = 0; d < 2; d++) begin
         e = (d == 0) ? e0 : e1;
         g = msk(got_vec(d), e);
         tests++;
         if (g !== e) begin
            fails++;
            $display("FAIL %s lat=%0d k=%0d got=%h exp=%h", nm, d + 1, k, g, e);
         end
      end
   endtask

   task automatic run_job(input int n, input bit rnd);
      @(negedge clk);
      start = 1'b1;
      n_in  = 8'(n);
      for (int k = 1; k <= n * n + 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk("job", k, exp_job(n, 1, k), exp_job(n, 2, k));
         // Extra Start pulses while both instances are mid-RUN must be ignored.
         if (rnd && k < n * n && $urandom_range(0, 3) == 0) begin
            start = 1'b1;
            n_in  = 8'($urandom_range(0, 255));
         end
      end
   endtask

   task automatic run_bad(input logic [7:0] n);
      @(negedge clk);
      start = 1'b1;
      n_in  = n;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk("bad_n", k, (k == 1) ? 37'h1 : 37'h0, (k == 1) ? 37'h1 : 37'h0);
      end
   endtask

   typedef struct {
      logic [7:0] n;
      bit         exp_err;
   } vec_t;

   vec_t tbl [9];

   initial begin
      tbl[0] = '{8'd0,   1'b1};
      tbl[1] = '{8'd200, 1'b1};
      tbl[2] = '{8'd129, 1'b1};
      tbl[3] = '{8'd255, 1'b1};
      tbl[4] = '{8'd1,   1'b0};
      tbl[5] = '{8'd2,   1'b0};
      tbl[6] = '{8'd3,   1'b0};
      tbl[7] = '{8'd5,   1'b0};
      tbl[8] = '{8'd128, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      n_in  = 8'd0;
      abort = 1'b0;
      #1;
      chk("reset", 0, 37'h0, 37'h0);
      @(negedge clk);
      chk("reset", 0, 37'h0, 37'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle", 0, 37'h0, 37'h0);

      for (int t = 0; t < 9; t++) begin
         if (tbl[t].exp_err) run_bad(tbl[t].n);
         else                run_job(int'(tbl[t].n), 1'b0);
      end

      // N=4 with a stray Start mid-RUN, then reset mid-RUN.
      @(negedge clk);
      start = 1'b1;
      n_in  = 8'd4;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk("midrun", k, exp_job(4, 1, k), exp_job(4, 2, k));
         if (k == 3) begin
            start = 1'b1;
            n_in  = 8'd2;
         end
      end
      rst_n = 1'b0;
      #1;
      chk("rst_async", 0, 37'h0, 37'h0);
      @(negedge clk);
      chk("rst_hold", 0, 37'h0, 37'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_idle", 0, 37'h0, 37'h0);
      run_job(1, 1'b0);

`ifdef MVC_ABORT_EN
      // Abort during the cycle that issues element 6 of an N=4 job.
      @(negedge clk);
      start = 1'b1;
      n_in  = 8'd4;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (k <= 7)      chk("abort", k, exp_job(4, 1, k), exp_job(4, 2, k));
         else if (k == 8) chk("abort", k, 37'h1, 37'h1);
         else             chk("abort", k, 37'h0, 37'h0);
         if (k == 7) abort = 1'b1;
      end
      run_job(2, 1'b0);
`endif

      for (int r = 0; r < 15; r++) begin
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 0) run_bad(8'd0);
            else                           run_bad(8'($urandom_range(129, 255)));
         end else begin
            run_job($urandom_range(1, 12), 1'b1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mv_seq_ctrl.md
# mv_seq_ctrl

Matrix-vector compute sequencer: after `DCD` has loaded matrix A (N×N, row-major) and vector X into their memories and pulses Start, this block sweeps both memories and drives the MAC datapath. It issues read addresses, marks row boundaries for the accumulator, and writes each row result into the Y memory. It asserts Done when all N rows are written. It sits between `DCD` (Start/N source, Done sink) and the A/X/Y memories plus MAC unit.

## Interface
Parameters:
- `RD_LAT`, 1: A/X memory read latency in cycles (1..4).
- `N_MAX`, 128: largest legal dimension.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `RST_n`  in  1  reset, asynchronous, active-low.
- `Start_in`  in  1  start request; sampled only in IDLE.
- `N_in`  in  8  dimension; latched when Start is accepted; legal range is 1..N_MAX.
- `A_Ena_out`  out  1  A memory read enable.
- `A_Addra_out`  out  14  A read address (row*N + col).
- `X_Ena_out`  out  1  X memory read enable.
- `X_Addra_out`  out  7  X read address (col).
- `Mac_en_out`  out  1  MAC operand valid; high while A/X read data is on the bus.
- `Mac_clr_out`  out  1  with Mac_en; the MAC loads the product instead of accumulating (column 0).
- `Mac_last_out`  out  1  with Mac_en; marks column N-1.
- `Y_Wena_out`  out  1  Y memory write enable.
- `Y_Addra_out`  out  7  Y write address (row).
- `Busy_out`  out  1  high while a job is in progress.
- `Done_out`  out  1  one-cycle completion pulse.
- `Err_out`  out  1  one-cycle pulse when Start is rejected.

## Operation
- States:
  - IDLE → RUN on Start with a legal N.
  - RUN → DRAIN after the issue of (row N-1, col N-1).
  - DRAIN → DONE when the last Y write occurs.
  - DONE → IDLE unconditionally.
- Illegal Start: N_in = 0 or N_in > N_MAX pulses Err_out for 1 cycle. The state stays IDLE and no enables are raised.
- Issue order in RUN, one element per cycle with no bubbles:
  - col increments 0..N-1, then wraps to 0 and row increments.
  - A_Addra increments by 1 every issue cycle, starting at 0.
  - X_Addra = col.
- Counters:
  - row and col are 7-bit.
  - Column wrap compares col against an 8-bit N-1.
  - A_Addra is a 14-bit incrementer, so N=128 ends at 16383 with no overflow.
- Side-band pipeline: a valid/clr/last/row shift register of depth RD_LAT aligns the MAC controls with memory read data.
- Start_in in any state other than IDLE is ignored, with no error.
- Reset values (also applied asynchronously whenever RST_n = 0): all outputs 0, state IDLE, counters 0, pipeline valids 0.

## Timing
- Let edge E be the edge at which Start is accepted. During cycle E+1:
  - A_Ena_out = X_Ena_out = 1.
  - A_Addra_out = 0.
  - Busy_out = 1.
- An issue in cycle t produces, in cycle t+RD_LAT, Mac_en_out=1, plus:
  - Mac_clr_out=1 if col was 0.
  - Mac_last_out=1 if col was N-1.
- Y write for a row: Y_Wena_out=1 with Y_Addra_out = row in the cycle after that row's Mac_last_out.
- Back-to-back rows: successive Y writes are exactly N cycles apart. For N=1, Y_Wena_out is high on consecutive cycles.
- Done_out pulses 1 cycle after the final Y write.
  - The total from the first issue cycle to Done is N*N + RD_LAT + 1 cycles.
  - Busy_out falls in the cycle after Done_out.
- Read enables drop in the cycle after the last issue. Mac/Y outputs are only high on valid pipeline slots.
- Reset mid-job: outputs return to 0 immediately and any in-flight pipeline entries are discarded. A Start after RST_n deasserts runs normally.

## Configuration
- `MVC_ABORT_EN`, defined:
  - Adds input `Abort_in` (1 bit).
  - When Abort_in is high in RUN or DRAIN, the next edge clears issue, pipeline valids and the Y write, and returns the state to IDLE.
  - Err_out pulses 1 cycle and Done_out is not pulsed. Busy_out falls with the abort edge.
  - Abort_in in IDLE/DONE is ignored.
- `MVC_ABORT_EN`, undefined: the port does not exist and a job always runs to Done.

## Test plan
- N=1, RD_LAT=1, Start at edge E:
  - A/X enable with address 0 in cycle E+1.
  - Mac_en=clr=last=1 in E+2.
  - Y_Wena with addr 0 in E+3.
  - Done in E+4.
  - Busy high E+1..E+4.
- N=2, RD_LAT=2:
  - A addresses 0,1,2,3 in consecutive cycles; X addresses 0,1,0,1.
  - Mac_clr on the 1st and 3rd Mac_en; Mac_last on the 2nd and 4th.
  - Y writes to addr 0 then addr 1, 2 cycles apart.
  - Done 1 cycle after the second write.
- N=128, RD_LAT=1:
  - 16384 issue cycles; last A_Addra = 16383, X_Addra = 127.
  - Exactly 128 Y writes (addresses 0..127).
  - Done 16386 cycles after the first issue.
- N_in=0, then N_in=200, each with Start:
  - Err pulses 1 cycle each.
  - Busy, all enables and Done stay 0.
- Start pulsed again mid-RUN (N=4): ignored, with no Err and no address restart. Then RST_n low mid-RUN:
  - All outputs 0 immediately.
  - After release, a Start with N=1 completes with the case-1 timing.
- `MVC_ABORT_EN` defined, N=4, Abort_in pulsed at issue 6:
  - Enables and Busy drop at the next edge.
  - Err pulses; Y writes seen are only addr 0; Done never pulses.
